// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter.
// State encoding, port identifiers and default timeout.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// A lone request wins outright; on contention the port that did not win last time goes.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    // Pick the winner from the current requests and the previous winner
    always_comb begin
        valid = req[0] | req[1];
        grant = PORT_CPU;
        if (req == 2'b10) begin
            grant = PORT_AUX;
        end else if (req == 2'b11) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one busywait-style data memory between the CPU port and an auxiliary port.
// Round-robin, non-preemptive, one transaction in flight, with a sticky timeout flag.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              P0_READ,
    input  logic              P0_WRITE,
    input  logic [ADDR_W-1:0] P0_ADDRESS,
    input  logic [DATA_W-1:0] P0_WRITEDATA,
    output logic [DATA_W-1:0] P0_READDATA,
    output logic              P0_BUSYWAIT,
    input  logic              P1_READ,
    input  logic              P1_WRITE,
    input  logic [ADDR_W-1:0] P1_ADDRESS,
    input  logic [DATA_W-1:0] P1_WRITEDATA,
    output logic [DATA_W-1:0] P1_READDATA,
    output logic              P1_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              TIMEOUT_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              req0;
    logic              req1;
    logic              pick_valid;
    logic              pick_grant;
    logic              grant;
    logic              is_write;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic              done_ok;
    logic              timed_out;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req0 = P0_READ | P0_WRITE;
    assign req1 = P1_READ | P1_WRITE;

    rr_pick2 u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    // Route the winning port's request; write beats read on the same port
    always_comb begin
        sel_write = P0_WRITE;
        sel_addr  = P0_ADDRESS;
        sel_wdata = P0_WRITEDATA;
        if (pick_grant == PORT_AUX) begin
            sel_write = P1_WRITE;
            sel_addr  = P1_ADDRESS;
            sel_wdata = P1_WRITEDATA;
        end
    end

    // The first ACCESS edge never completes: memory raises busywait combinationally
    assign done_ok   = (wait_cnt != '0) && !MEM_BUSYWAIT;
    assign timed_out = !done_ok && (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (done_ok || timed_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stall each requester until its own DONE cycle
    always_comb begin
        P0_BUSYWAIT = req0 & ~((state == ST_DONE) & (grant == PORT_CPU));
        P1_BUSYWAIT = req1 & ~((state == ST_DONE) & (grant == PORT_AUX));
    end

    // Latch the granted request, drive memory, count the wait and return results
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant         <= PORT_CPU;
            is_write      <= 1'b0;
            last_grant    <= PORT_AUX;
            wait_cnt      <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            P0_READDATA   <= '0;
            P1_READDATA   <= '0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant         <= pick_grant;
                        is_write      <= sel_write;
                        wait_cnt      <= '0;
                        MEM_READ      <= ~sel_write;
                        MEM_WRITE     <= sel_write;
                        MEM_ADDRESS   <= sel_addr;
                        MEM_WRITEDATA <= sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (done_ok) begin
                        if (!is_write) begin
                            if (grant == PORT_AUX) begin
                                P1_READDATA <= MEM_READDATA;
                            end else begin
                                P0_READDATA <= MEM_READDATA;
                            end
                        end
                        MEM_READ   <= 1'b0;
                        MEM_WRITE  <= 1'b0;
                        last_grant <= grant;
                    end else if (timed_out) begin
                        if (!is_write) begin
                            if (grant == PORT_AUX) begin
                                P1_READDATA <= '0;
                            end else begin
                                P0_READDATA <= '0;
                            end
                        end
                        MEM_READ      <= 1'b0;
                        MEM_WRITE     <= 1'b0;
                        MEM_ADDRESS   <= '0;
                        MEM_WRITEDATA <= '0;
                        TIMEOUT_ERR   <= 1'b1;
                        last_grant    <= grant;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter.
// Includes a small busywait memory model with a two-cycle latency and a stuck mode.
module tb_data_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       P0_READ, P0_WRITE, P1_READ, P1_WRITE;
    logic [7:0] P0_ADDRESS, P0_WRITEDATA, P1_ADDRESS, P1_WRITEDATA;
    logic [7:0] P0_READDATA, P1_READDATA;
    logic       P0_BUSYWAIT, P1_BUSYWAIT;
    logic       MEM_READ, MEM_WRITE;
    logic [7:0] MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;
    logic       MEM_BUSYWAIT;
    logic       TIMEOUT_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic       stuck;
    int         mem_cnt;
    logic [7:0] mem [0:255];

    data_mem_arbiter dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .P0_READ       (P0_READ),
        .P0_WRITE      (P0_WRITE),
        .P0_ADDRESS    (P0_ADDRESS),
        .P0_WRITEDATA  (P0_WRITEDATA),
        .P0_READDATA   (P0_READDATA),
        .P0_BUSYWAIT   (P0_BUSYWAIT),
        .P1_READ       (P1_READ),
        .P1_WRITE      (P1_WRITE),
        .P1_ADDRESS    (P1_ADDRESS),
        .P1_WRITEDATA  (P1_WRITEDATA),
        .P1_READDATA   (P1_READDATA),
        .P1_BUSYWAIT   (P1_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for the first two cycles of any access, or forever when stuck
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (stuck || mem_cnt < 2);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) begin
            mem_cnt     <= 0;
            mem[8'h20]  <= 8'h5C;
            mem[8'h30]  <= 8'h11;
            mem[8'h40]  <= 8'h22;
        end else begin
            if (MEM_READ | MEM_WRITE) mem_cnt <= mem_cnt + 1;
            else mem_cnt <= 0;
            if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    task automatic wait_free(input logic port, output int n);
        n = 0;
        while (((port ? P1_BUSYWAIT : P0_BUSYWAIT) == 1'b1) && n < 100) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %h want 0", MEM_READ); end
        n_checks++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %h want 0", MEM_WRITE); end
        n_checks++; if (MEM_ADDRESS !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 00", MEM_ADDRESS); end
        n_checks++; if (MEM_WRITEDATA !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 00", MEM_WRITEDATA); end
        n_checks++; if (P0_READDATA !== 8'h00) begin n_fail++; $display("FAIL rst_p0_rdata: got %h want 00", P0_READDATA); end
        n_checks++; if (P1_READDATA !== 8'h00) begin n_fail++; $display("FAIL rst_p1_rdata: got %h want 00", P1_READDATA); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %h want 0", TIMEOUT_ERR); end
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++; if (P0_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_p0_busy: got %h want 0", P0_BUSYWAIT); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL rst_idle_read: got %h want 0", MEM_READ); end
    endtask

    task automatic test_write();
        int n;
        P0_WRITE = 1'b1; P0_ADDRESS = 8'h10; P0_WRITEDATA = 8'h2A;
        #1;
        n_checks++; if (P0_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL wr_busy_now: got %h want 1", P0_BUSYWAIT); end
        @(negedge CLK);
        n_checks++; if (MEM_WRITE !== 1'b1) begin n_fail++; $display("FAIL wr_mem_write: got %h want 1", MEM_WRITE); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL wr_mem_read: got %h want 0", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h10) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 10", MEM_ADDRESS); end
        n_checks++; if (MEM_WRITEDATA !== 8'h2A) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want 2a", MEM_WRITEDATA); end
        n_checks++; if (P1_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL wr_p1_busy: got %h want 0", P1_BUSYWAIT); end
        wait_free(1'b0, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", n); end
        n_checks++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL wr_done_write: got %h want 0", MEM_WRITE); end
        n_checks++; if (mem[8'h10] !== 8'h2A) begin n_fail++; $display("FAIL wr_mem_content: got %h want 2a", mem[8'h10]); end
        P0_WRITE = 1'b0;
        @(negedge CLK);
        n_checks++; if (P0_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy: got %h want 0", P0_BUSYWAIT); end
    endtask

    task automatic test_read();
        int n;
        P0_READ = 1'b1; P0_ADDRESS = 8'h10;
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL rd_mem_read: got %h want 1", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h10) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 10", MEM_ADDRESS); end
        wait_free(1'b0, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", n); end
        n_checks++; if (P0_READDATA !== 8'h2A) begin n_fail++; $display("FAIL rd_p0_rdata: got %h want 2a", P0_READDATA); end
        n_checks++; if (P1_READDATA !== 8'h00) begin n_fail++; $display("FAIL rd_p1_rdata: got %h want 00", P1_READDATA); end
        P0_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_simultaneous();
        int n;
        int viol;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        P0_READ = 1'b1; P0_ADDRESS = 8'h10;
        P1_READ = 1'b1; P1_ADDRESS = 8'h20;
        @(negedge CLK);
        n_checks++; if (MEM_ADDRESS !== 8'h10) begin n_fail++; $display("FAIL sim_first_addr: got %h want 10", MEM_ADDRESS); end
        n_checks++; if (P1_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL sim_p1_busy: got %h want 1", P1_BUSYWAIT); end
        n = 0; viol = 0;
        while (P0_BUSYWAIT == 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
            if (P1_BUSYWAIT !== 1'b1) viol++;
        end
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL sim_p0_latency: got %0d want 3", n); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL sim_p1_stall: got %0d drops want 0", viol); end
        n_checks++; if (P0_READDATA !== 8'h2A) begin n_fail++; $display("FAIL sim_p0_rdata: got %h want 2a", P0_READDATA); end
        n_checks++; if (P1_READDATA !== 8'h00) begin n_fail++; $display("FAIL sim_p1_untouched: got %h want 00", P1_READDATA); end
        P0_READ = 1'b0;
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL sim_idle_read: got %h want 0", MEM_READ); end
        n_checks++; if (P1_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL sim_idle_p1_busy: got %h want 1", P1_BUSYWAIT); end
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL sim_second_read: got %h want 1", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h20) begin n_fail++; $display("FAIL sim_second_addr: got %h want 20", MEM_ADDRESS); end
        wait_free(1'b1, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL sim_p1_latency: got %0d want 3", n); end
        n_checks++; if (P1_READDATA !== 8'h5C) begin n_fail++; $display("FAIL sim_p1_rdata: got %h want 5c", P1_READDATA); end
        n_checks++; if (P0_READDATA !== 8'h2A) begin n_fail++; $display("FAIL sim_p0_kept: got %h want 2a", P0_READDATA); end
        P1_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_addr [4];
        logic       prev;
        int         got;
        int         cyc;
        exp_addr[0] = 8'h30; exp_addr[1] = 8'h40;
        exp_addr[2] = 8'h30; exp_addr[3] = 8'h40;
        P0_READ = 1'b1; P0_ADDRESS = 8'h30;
        P1_READ = 1'b1; P1_ADDRESS = 8'h40;
        prev = MEM_READ;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (MEM_READ && !prev) begin
                n_checks++;
                if (MEM_ADDRESS !== exp_addr[got]) begin
                    n_fail++;
                    $display("FAIL b2b_order_%0d: got addr %h want %h", got, MEM_ADDRESS, exp_addr[got]);
                end
                got++;
            end
            prev = MEM_READ;
        end
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d grants want 4", got); end
        P0_READ = 1'b0;
        P1_READ = 1'b0;
        repeat (6) @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %h want 0", MEM_READ); end
        n_checks++; if (P0_READDATA !== 8'h11) begin n_fail++; $display("FAIL b2b_p0_rdata: got %h want 11", P0_READDATA); end
    endtask

    task automatic test_timeout();
        int n;
        stuck = 1'b1;
        P1_READ = 1'b1; P1_ADDRESS = 8'h20;
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL to_mem_read: got %h want 1", MEM_READ); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %h want 0", TIMEOUT_ERR); end
        wait_free(1'b1, n);
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL to_cycles: got %0d want 32", n); end
        n_checks++; if (TIMEOUT_ERR !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %h want 1", TIMEOUT_ERR); end
        n_checks++; if (P1_READDATA !== 8'h00) begin n_fail++; $display("FAIL to_p1_rdata: got %h want 00", P1_READDATA); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL to_mem_read_off: got %h want 0", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h00) begin n_fail++; $display("FAIL to_mem_addr_off: got %h want 00", MEM_ADDRESS); end
        @(negedge CLK);
        n_checks++; if (P1_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL to_one_cycle: got %h want 1", P1_BUSYWAIT); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL to_idle_read: got %h want 0", MEM_READ); end
        P1_READ = 1'b0;
        stuck = 1'b0;
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL to_no_regrant: got %h want 0", MEM_READ); end
        n_checks++; if (TIMEOUT_ERR !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %h want 1", TIMEOUT_ERR); end
    endtask

    task automatic test_reset_mid_access();
        int n;
        P0_WRITE = 1'b1; P0_ADDRESS = 8'h50; P0_WRITEDATA = 8'h77;
        @(negedge CLK);
        n_checks++; if (MEM_WRITE !== 1'b1) begin n_fail++; $display("FAIL rma_started: got %h want 1", MEM_WRITE); end
        RESET = 1'b1;
        P0_WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        n_checks++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL rma_mem_write: got %h want 0", MEM_WRITE); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL rma_mem_read: got %h want 0", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h00) begin n_fail++; $display("FAIL rma_mem_addr: got %h want 00", MEM_ADDRESS); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL rma_timeout: got %h want 0", TIMEOUT_ERR); end
        n_checks++; if (P0_READDATA !== 8'h00) begin n_fail++; $display("FAIL rma_p0_rdata: got %h want 00", P0_READDATA); end
        n_checks++; if (P1_READDATA !== 8'h00) begin n_fail++; $display("FAIL rma_p1_rdata: got %h want 00", P1_READDATA); end
        P0_READ = 1'b1; P0_ADDRESS = 8'h10;
        @(negedge CLK);
        n_checks++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL rma_new_read: got %h want 1", MEM_READ); end
        n_checks++; if (MEM_ADDRESS !== 8'h10) begin n_fail++; $display("FAIL rma_new_addr: got %h want 10", MEM_ADDRESS); end
        wait_free(1'b0, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rma_latency: got %0d want 3", n); end
        n_checks++; if (P0_READDATA !== 8'h2A) begin n_fail++; $display("FAIL rma_p0_result: got %h want 2a", P0_READDATA); end
        P0_READ = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        stuck = 1'b0;
        P0_READ = 1'b0; P0_WRITE = 1'b0; P0_ADDRESS = 8'h00; P0_WRITEDATA = 8'h00;
        P1_READ = 1'b0; P1_WRITE = 1'b0; P1_ADDRESS = 8'h00; P1_WRITEDATA = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single 8-bit data_memory (READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake) between the CPU data port (port 0) and a second master (port 1, e.g. a memory-load/debug engine).
- Each port sees the same busywait interface the CPU already uses, so the CPU connects unchanged.
- Arbitration is round-robin and non-preemptive; one memory transaction is in flight at a time.

Parameters:
- ADDR_W, 8, address width of ports and memory.
- DATA_W, 8, data width of ports and memory.
- TIMEOUT_CYCLES, 32, maximum ACCESS cycles before a transaction is force-completed.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- P0_READ  in  1  port 0 read request; P0_WRITE  in  1  port 0 write request.
- P0_ADDRESS  in  ADDR_W  port 0 address; P0_WRITEDATA  in  DATA_W  port 0 store data.
- P0_READDATA  out  DATA_W  port 0 load data (registered); P0_BUSYWAIT  out  1  port 0 stall.
- P1_READ, P1_WRITE, P1_ADDRESS, P1_WRITEDATA, P1_READDATA, P1_BUSYWAIT: same as port 0.
- MEM_READ  out  1; MEM_WRITE  out  1; MEM_ADDRESS  out  ADDR_W; MEM_WRITEDATA  out  DATA_W (all registered).
- MEM_READDATA  in  DATA_W; MEM_BUSYWAIT  in  1  data_memory interface.
- TIMEOUT_ERR  out  1  sticky, set on any forced completion.

Behaviour:
- Clock and reset: single clock CLK; reset RESET is synchronous, active-high.
- Reset values:
  - state=IDLE, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - P0_READDATA=P1_READDATA=0, TIMEOUT_ERR=0, wait counter=0.
  - last_grant=1, so port 0 wins the first contention.
- Request: reqX = PX_READ | PX_WRITE. If both are set on one port, write wins and the read is ignored.
- PX_BUSYWAIT (combinational) = reqX & ~(state==DONE & grant==X). Asserts in the same cycle a request appears, so the requester stalls at the next posedge.
- IDLE:
  - No request: stay.
  - Exactly one request: grant it.
  - Both: grant the port != last_grant.
  - On the granting posedge, latch grant, rw, address and writedata; drive MEM_READ/MEM_WRITE from the latch; clear the counter; go to ACCESS.
- ACCESS:
  - MEM_* are held constant from the latch; the counter increments every cycle.
  - Completion is the first posedge with counter>=1 and MEM_BUSYWAIT==0. The first ACCESS edge is never a completion, because memory raises busywait combinationally.
  - On completion: if read, PX_READDATA<=MEM_READDATA for the granted port only; MEM_READ=MEM_WRITE<=0; last_grant<=grant; go to DONE.
  - Timeout: if the counter reaches TIMEOUT_CYCLES first, force-complete. MEM_* <= 0, PX_READDATA<=0 if read, TIMEOUT_ERR<=1 (cleared only by RESET), go to DONE.
- DONE (exactly 1 cycle):
  - Granted port's busywait is low; the requester advances and drops or changes its request at the next posedge.
  - No arbitration happens in DONE. Next state is IDLE, and the other port's pending request is granted in IDLE.
- Latency:
  - Request seen at posedge k gives MEM_* asserted after k.
  - Memory completion at posedge m gives READDATA valid and busywait low after m.
  - The requester resumes at m+1; the arbiter adds 2 cycles of overhead per access.
- A requester dropping its request during ACCESS does not abort; the transaction completes and its result is discarded harmlessly.
- Un-granted port: its readdata is never modified, and it sees busywait high for the whole other transaction.
- Simultaneous requests at reset deassertion: port 0 first, then port 1.
- Reset mid-ACCESS: on the reset edge, all outputs return to reset values and any in-flight transaction is abandoned. data_memory is reset alongside.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2;
  - port ids PORT_CPU=1'b0, PORT_AUX=1'b1;
  - default TIMEOUT_CYCLES.
- One sub-module, rr_pick2: combinational two-way round-robin picker (req[1:0], last_grant) -> (valid, grant).
- The FSM, latches and counter stay in data_mem_arbiter.

Test Plan:
- Reset, then P0 write 8'h2A to address 8'h10 alone -> MEM_WRITE high with MEM_ADDRESS=8'h10 and MEM_WRITEDATA=8'h2A after the next edge. P0_BUSYWAIT stays high until one cycle after memory completes; P1_BUSYWAIT stays 0.
- P0 read of 8'h10 after that write -> P0_READDATA=8'h2A in the DONE cycle; P1_READDATA stays 8'h00.
- P0 and P1 reads asserted on the same edge, right after reset -> port 0 is served first and port 1 second. P1 is served with no gap beyond DONE->IDLE, and port 1 stays busy throughout port 0's access.
- Back-to-back: both ports continuously requesting for 4 transactions -> grant order 0,1,0,1, with each MEM_ADDRESS matching its port.
- Memory model holding MEM_BUSYWAIT high forever, with P1 reading -> after 32 ACCESS cycles: TIMEOUT_ERR=1, P1_READDATA=8'h00, P1_BUSYWAIT low for 1 cycle, FSM back in IDLE.
- RESET pulsed for one edge mid-ACCESS -> next cycle MEM_READ=MEM_WRITE=0, TIMEOUT_ERR=0, both readdata=0. A subsequent P0 request is served normally.
